// File: rtl/alu_exec_stage.sv
// -----------------------------------------------------------------------------
// alu_exec_stage
//   Single-issue ALU execute stage. One request is accepted per valid/ready
//   handshake and its operands are latched. SRA is delegated to an external
//   combinational unit fed from the latched operands; all other ops are
//   computed here, MUL iteratively (shift-add, one multiplier bit per cycle).
//   The registered result is held on a valid/ready output until it is taken.
//
// Ports
//   clk, resetn                 clock, asynchronous active-low reset
//   in_valid/in_ready           request handshake
//   in_op, in_a, in_b, in_tag   opcode, operands, opaque tag
//   sra_a, sra_x, sra_result    external SRA unit: operand, amount, result
//   out_valid/out_ready         result handshake
//   out_result, out_zero        result and (result == 0)
//   out_err, out_tag            illegal opcode flag, echoed tag
// -----------------------------------------------------------------------------
module alu_exec_stage #(
   parameter int TAG_W  = 4,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic [31:0]      sra_a,
   output logic [31:0]      sra_x,
   input  logic [31:0]      sra_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic             out_zero,
   output logic             out_err,
   output logic [TAG_W-1:0] out_tag
);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLL  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_SRA  = 4'd7;
   localparam logic [3:0] OP_SLT  = 4'd8;
   localparam logic [3:0] OP_SLTU = 4'd9;
   localparam logic [3:0] OP_MUL  = 4'd10;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_HOLD} state_t;

   state_t             state_q, state_d;
   logic [3:0]         op_q, op_d;
   logic [31:0]        a_q, a_d;
   logic [31:0]        b_q, b_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic [4:0]         cnt_q, cnt_d;
   logic [31:0]        acc_q, acc_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic [31:0]        out_result_q, out_result_d;
   logic               out_zero_q, out_zero_d;
   logic               out_err_q, out_err_d;
   logic [TAG_W-1:0]   out_tag_q, out_tag_d;

   logic [31:0]        exec_result;
   logic               exec_err;
   logic [31:0]        mul_next;

   // Single-cycle datapath from the latched operands. Opcode 10 only reaches
   // this path when MUL is disabled, so it is illegal here.
   always_comb begin
      exec_result = 32'd0;
      exec_err    = 1'b0;
      case (op_q)
         OP_ADD:  exec_result = a_q + b_q;
         OP_SUB:  exec_result = a_q - b_q;
         OP_AND:  exec_result = a_q & b_q;
         OP_OR:   exec_result = a_q | b_q;
         OP_XOR:  exec_result = a_q ^ b_q;
         OP_SLL:  exec_result = a_q << b_q[4:0];
         OP_SRL:  exec_result = a_q >> b_q[4:0];
         OP_SRA:  exec_result = sra_result;
         OP_SLT:  exec_result = {31'd0, $signed(a_q) < $signed(b_q)};
         OP_SLTU: exec_result = {31'd0, a_q < b_q};
         default: exec_err    = 1'b1;
      endcase
   end

   // One shift-add step: add A<<cnt when multiplier bit cnt is set. A and B
   // are never shifted in place so sra_a/sra_x stay fixed after the accept.
   assign mul_next = b_q[cnt_q] ? (acc_q + (a_q << cnt_q)) : acc_q;

   // NOTE: every signal gets a hold-value default first so no path leaves it
   // unassigned; that is what keeps this block free of inferred latches.
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      tag_d        = tag_q;
      cnt_d        = cnt_q;
      acc_d        = acc_q;
      out_valid_d  = out_valid_q;
      out_result_d = out_result_q;
      out_zero_d   = out_zero_q;
      out_err_d    = out_err_q;
      out_tag_d    = out_tag_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               op_d    = in_op;
               a_d     = in_a;
               b_d     = in_b;
               tag_d   = in_tag;
               cnt_d   = 5'd0;
               acc_d   = 32'd0;
               state_d = (MUL_EN && in_op == OP_MUL) ? S_MUL : S_EXEC;
            end
         end
         S_EXEC: begin
            out_result_d = exec_result;
            out_err_d    = exec_err;
            out_zero_d   = (exec_result == 32'd0);
            out_tag_d    = tag_q;
            out_valid_d  = 1'b1;
            state_d      = S_HOLD;
         end
         S_MUL: begin
            acc_d = mul_next;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               out_result_d = mul_next;
               out_err_d    = 1'b0;
               out_zero_d   = (mul_next == 32'd0);
               out_tag_d    = tag_q;
               out_valid_d  = 1'b1;
               state_d      = S_HOLD;
            end
         end
         S_HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Registered ready: low throughout reset, high the cycle after the
      // stage returns to IDLE.
      in_ready_d = (state_d == S_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= S_IDLE;
         op_q         <= 4'd0;
         a_q          <= 32'd0;
         b_q          <= 32'd0;
         tag_q        <= '0;
         cnt_q        <= 5'd0;
         acc_q        <= 32'd0;
         in_ready_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         out_result_q <= 32'd0;
         out_zero_q   <= 1'b0;
         out_err_q    <= 1'b0;
         out_tag_q    <= '0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         a_q          <= a_d;
         b_q          <= b_d;
         tag_q        <= tag_d;
         cnt_q        <= cnt_d;
         acc_q        <= acc_d;
         in_ready_q   <= in_ready_d;
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
         out_zero_q   <= out_zero_d;
         out_err_q    <= out_err_d;
         out_tag_q    <= out_tag_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign sra_a      = a_q;
   assign sra_x      = b_q;
   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign out_zero   = out_zero_q;
   assign out_err    = out_err_q;
   assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_stage
//   Self-checking bench for alu_exec_stage: directed vector table, hand-written
//   backpressure / ready-high / reset-abort sequences, and random operations
//   checked against an arithmetic reference model. The external SRA unit is
//   modelled here as a plain arithmetic shift.
// -----------------------------------------------------------------------------
module tb_alu_exec_stage;

   logic        clk = 1'b0;
   logic        resetn;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [3:0]  in_tag;
   logic [31:0] sra_a;
   logic [31:0] sra_x;
   logic [31:0] sra_result;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_zero;
   logic        out_err;
   logic [3:0]  out_tag;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   // External SRA unit: arithmetic shift by the low five bits of the amount.
   assign sra_result = $unsigned($signed(sra_a) >>> sra_x[4:0]);

   alu_exec_stage #(.TAG_W(4), .MUL_EN(1'b1)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_tag     (in_tag),
      .sra_a      (sra_a),
      .sra_x      (sra_x),
      .sra_result (sra_result),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_zero   (out_zero),
      .out_err    (out_err),
      .out_tag    (out_tag)
   );

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        err;
      int          lat;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference model: {err, result} from the opcode rules.
   function automatic logic [32:0] ref_op(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      logic [63:0] prod;
      case (op)
         4'd0:  return {1'b0, a + b};
         4'd1:  return {1'b0, a - b};
         4'd2:  return {1'b0, a & b};
         4'd3:  return {1'b0, a | b};
         4'd4:  return {1'b0, a ^ b};
         4'd5:  return {1'b0, a << (b % 32)};
         4'd6:  return {1'b0, a >> (b % 32)};
         4'd7:  return {1'b0, $unsigned($signed(a) >>> (b % 32))};
         4'd8:  return {1'b0, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0};
         4'd9:  return {1'b0, (a < b) ? 32'd1 : 32'd0};
         4'd10: begin
            prod = {32'd0, a} * {32'd0, b};
            return {1'b0, prod[31:0]};
         end
         default: return {1'b1, 32'd0};
      endcase
   endfunction

   // Present a request, wait for acceptance and then for out_valid. Returns
   // the number of edges from the accept edge until out_valid was seen.
   // Called and returns at #1 after a rising edge.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, output int lat);
      int  n = 0;
      bit  busy_ok = 1'b1;
      in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1; n++;
      end
      if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      check("sra_a_latched", sra_a, a);
      check("sra_x_latched", sra_x, b);
      while (!out_valid && lat < 200) begin
         if (in_ready) busy_ok = 1'b0;
         @(posedge clk); #1; lat++;
      end
      check("in_ready_low_busy", {31'd0, busy_ok}, 32'd1);
   endtask

   task automatic check_out(input string name, input logic [3:0] op, input logic [31:0] res,
                            input logic err, input logic [3:0] tag, input int lat, input int exp_lat);
      check({name, "_valid"},  {31'd0, out_valid}, 32'd1);
      check({name, "_latency"}, lat, exp_lat);
      check({name, "_result"}, out_result, res);
      check({name, "_err"},    {31'd0, out_err}, {31'd0, err});
      check({name, "_zero"},   {31'd0, out_zero}, {31'd0, res == 32'd0});
      check({name, "_tag"},    {28'd0, out_tag}, {28'd0, tag});
      if (op == 4'd7) check({name, "_sra_x_during_hold"}, sra_x, in_b);
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("hs_out_valid_low", {31'd0, out_valid}, 32'd0);
      check("hs_in_ready_high", {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      vec_t        vecs[$];
      int          lat;
      logic [32:0] exp;
      logic [31:0] held_res;
      logic [3:0]  op;
      logic [31:0] a, b;

      vecs.push_back('{4'd7,  32'h8000_0000, 32'd4,        32'hF800_0000, 1'b0, 2});
      vecs.push_back('{4'd7,  32'h7FFF_FFF0, 32'd36,       32'h07FF_FFFF, 1'b0, 2});
      vecs.push_back('{4'd6,  32'h0000_00F0, 32'd36,       32'h0000_000F, 1'b0, 2});
      vecs.push_back('{4'd0,  32'hFFFF_FFFF, 32'd1,        32'h0000_0000, 1'b0, 2});
      vecs.push_back('{4'd8,  32'hFFFF_FFFF, 32'd1,        32'h0000_0001, 1'b0, 2});
      vecs.push_back('{4'd9,  32'hFFFF_FFFF, 32'd1,        32'h0000_0000, 1'b0, 2});
      vecs.push_back('{4'd10, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 1'b0, 33});
      vecs.push_back('{4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b1, 2});
      vecs.push_back('{4'd1,  32'd5,         32'd7,        32'hFFFF_FFFE, 1'b0, 2});
      vecs.push_back('{4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 2});
      vecs.push_back('{4'd3,  32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 2});
      vecs.push_back('{4'd4,  32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 1'b0, 2});
      vecs.push_back('{4'd5,  32'd1,         32'd63,       32'h8000_0000, 1'b0, 2});
      vecs.push_back('{4'd15, 32'd0,         32'd0,        32'h0000_0000, 1'b1, 2});

      resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_op = 4'd0; in_a = 32'd0; in_b = 32'd0; in_tag = 4'd0;
      #3;
      check("rst_in_ready",   {31'd0, in_ready}, 32'd0);
      check("rst_out_valid",  {31'd0, out_valid}, 32'd0);
      check("rst_out_result", out_result, 32'd0);
      check("rst_out_err",    {31'd0, out_err}, 32'd0);
      check("rst_out_zero",   {31'd0, out_zero}, 32'd0);
      check("rst_out_tag",    {28'd0, out_tag}, 32'd0);
      check("rst_sra_a",      sra_a, 32'd0);
      check("rst_sra_x",      sra_x, 32'd0);
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;

      // Directed vectors.
      for (int i = 0; i < vecs.size(); i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, 4'(i), lat);
         check_out($sformatf("vec%0d", i), vecs[i].op, vecs[i].res, vecs[i].err, 4'(i), lat, vecs[i].lat);
         handshake();
      end

      // Backpressure: result held for 5 cycles while in_valid pokes at the stage.
      issue(4'd0, 32'd100, 32'd23, 4'hA, lat);
      check("bp_result", out_result, 32'd123);
      held_res = out_result;
      in_valid = 1'b1; in_op = 4'd1; in_a = 32'hDEAD_BEEF; in_b = 32'h1; in_tag = 4'h3;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check("bp_valid_held",  {31'd0, out_valid}, 32'd1);
         check("bp_result_held", out_result, held_res);
         check("bp_tag_held",    {28'd0, out_tag}, 32'hA);
         check("bp_in_ready",    {31'd0, in_ready}, 32'd0);
         check("bp_sra_a_held",  sra_a, 32'd100);
      end
      in_valid = 1'b0;
      handshake();

      // out_ready already high: handshake on the first edge in HOLD.
      out_ready = 1'b1;
      issue(4'd4, 32'h0000_FFFF, 32'h0000_00FF, 4'h5, lat);
      check("rdy_latency", lat, 2);
      check("rdy_result", out_result, 32'h0000_FF00);
      @(posedge clk); #1;
      check("rdy_valid_dropped", {31'd0, out_valid}, 32'd0);
      check("rdy_in_ready", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b0;

      // Reset at MUL iteration 10 aborts the operation.
      in_op = 4'd10; in_a = 32'd7; in_b = 32'd9; in_tag = 4'h9; in_valid = 1'b1;
      for (int n = 0; n < 50 && !in_ready; n++) begin
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1 resetn = 1'b0;
      #1;
      check("abort_out_valid", {31'd0, out_valid}, 32'd0);
      check("abort_in_ready",  {31'd0, in_ready}, 32'd0);
      check("abort_sra_a",     sra_a, 32'd0);
      check("abort_out_tag",   {28'd0, out_tag}, 32'd0);
      #2 resetn = 1'b1;
      @(posedge clk); #1;
      check("post_rst_in_ready",  {31'd0, in_ready}, 32'd1);
      check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
      issue(4'd0, 32'd2, 32'd3, 4'h6, lat);
      check_out("post_rst_add", 4'd0, 32'd5, 1'b0, 4'h6, lat, 2);
      handshake();

      // Random operations against the reference model.
      for (int i = 0; i < 40; i++) begin
         op = 4'($urandom_range(0, 15));
         a  = $urandom;
         b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         exp = ref_op(op, a, b);
         issue(op, a, b, 4'(i), lat);
         check_out($sformatf("rnd%0d_op%0d", i, op), op, exp[31:0], exp[32], 4'(i), lat,
                   (op == 4'd10) ? 33 : 2);
         handshake();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
